// File: rtl/bus_responder_if.sv
// rtl/bus_responder_if.sv - core data bus and interrupt lines between core and bus_responder
interface bus_responder_if;
    logic [63:0] bus_address;
    logic        bus_read_enable;
    logic        bus_write_enable;
    logic [63:0] bus_write_data;
    logic [63:0] bus_read_data;
    logic [3:0]  interrupt_vector;
    logic        interrupt_ack;

    modport master (
        output bus_address, bus_read_enable, bus_write_enable, bus_write_data, interrupt_ack,
        input  bus_read_data, interrupt_vector
    );

    modport slave (
        input  bus_address, bus_read_enable, bus_write_enable, bus_write_data, interrupt_ack,
        output bus_read_data, interrupt_vector
    );
endinterface

// File: rtl/bus_responder.sv
// rtl/bus_responder.sv - memory-mapped key FIFO, UART TX holding register and key interrupt FSM
module bus_responder #(
    parameter logic [63:0] KEY_ADDR   = 64'h0000_0000_F000_0000,
    parameter logic [63:0] ART_ADDR   = 64'h0000_0000_F000_0100,
    parameter logic [63:0] STAT_ADDR  = KEY_ADDR + 64'd8,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    bus_responder_if.slave   bus,
    input  logic             key_valid,
    input  logic [7:0]       key_data,
    output logic             tx_valid,
    output logic [7:0]       tx_data,
    input  logic             tx_ready
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [1:0] IRQ_IDLE    = 2'd0;
    localparam logic [1:0] IRQ_RAISED  = 2'd1;
    localparam logic [1:0] IRQ_SERVICE = 2'd2;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [7:0]    mem_d [FIFO_DEPTH];
    logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d, tx_drop_q, tx_drop_d, irq_en_q, irq_en_d;
    logic          tx_valid_q, tx_valid_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic [63:0]   rdata_q, rdata_d;
    logic [1:0]    state_q, state_d;
    logic [3:0]    vec_q, vec_d;

    logic        rd_key, rd_stat, wr_art, wr_stat;
    logic        empty, full, pop, push_ok, tx_hs;
    logic [63:0] stat_v, count_ext;

    assign rd_key  = bus.bus_read_enable  && (bus.bus_address == KEY_ADDR);
    assign rd_stat = bus.bus_read_enable  && (bus.bus_address == STAT_ADDR);
    assign wr_art  = bus.bus_write_enable && (bus.bus_address == ART_ADDR);
    assign wr_stat = bus.bus_write_enable && (bus.bus_address == STAT_ADDR);

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(FIFO_DEPTH));
    assign pop     = rd_key && !empty;
    // A pop frees the slot a same-cycle push needs when the FIFO is full.
    assign push_ok = key_valid && (!full || pop);
    assign tx_hs   = tx_valid_q && tx_ready;

    always_comb begin
        count_ext   = 64'(count_q);
        stat_v      = '0;
        stat_v[0]   = !empty;
        stat_v[1]   = full;
        stat_v[2]   = tx_valid_q;
        stat_v[3]   = overflow_q;
        stat_v[4]   = tx_drop_q;
        stat_v[5]   = irq_en_q;
        stat_v[8:6] = count_ext[2:0];
    end

    always_comb begin
        mem_d  = mem_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (push_ok) begin
            mem_d[wptr_q] = key_data;
            wptr_d        = wptr_q + 1'b1;
        end
        if (pop) begin
            rptr_d = rptr_q + 1'b1;
        end
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        rdata_d = rdata_q;
        if (bus.bus_read_enable) begin
            if (pop)          rdata_d = {55'b0, 1'b1, mem_q[rptr_q]};
            else if (rd_stat) rdata_d = stat_v;
            else              rdata_d = '0;
        end

        // Set events take priority over the clear-on-status-read.
        overflow_d = (key_valid && full && !pop) || (overflow_q && !rd_stat);
        tx_drop_d  = (wr_art && tx_valid_q && !tx_hs) || (tx_drop_q && !rd_stat);
        irq_en_d   = wr_stat ? bus.bus_write_data[0] : irq_en_q;

        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        if (wr_art && (!tx_valid_q || tx_hs)) begin
            tx_valid_d = 1'b1;
            tx_data_d  = bus.bus_write_data[7:0];
        end else if (tx_hs) begin
            tx_valid_d = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IRQ_IDLE:    if (irq_en_q && !empty)  state_d = IRQ_RAISED;
            IRQ_RAISED:  if (!irq_en_q)           state_d = IRQ_IDLE;
                         else if (bus.interrupt_ack) state_d = IRQ_SERVICE;
            IRQ_SERVICE: if (rd_key)              state_d = IRQ_IDLE;
            default:                              state_d = IRQ_IDLE;
        endcase
        vec_d = (state_d == IRQ_RAISED) ? 4'd1 : 4'd0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            tx_drop_q  <= 1'b0;
            irq_en_q   <= 1'b1;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            rdata_q    <= '0;
            state_q    <= IRQ_IDLE;
            vec_q      <= '0;
        end else begin
            mem_q      <= mem_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            tx_drop_q  <= tx_drop_d;
            irq_en_q   <= irq_en_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            rdata_q    <= rdata_d;
            state_q    <= state_d;
            vec_q      <= vec_d;
        end
    end

    assign bus.bus_read_data    = rdata_q;
    assign bus.interrupt_vector = vec_q;
    assign tx_valid             = tx_valid_q;
    assign tx_data              = tx_data_q;
endmodule

// File: tb/tb_bus_responder.sv
// tb/tb_bus_responder.sv - vector table and scoreboard bench for bus_responder
module tb_bus_responder;
    localparam logic [63:0] KEY  = 64'h0000_0000_F000_0000;
    localparam logic [63:0] ART  = 64'h0000_0000_F000_0100;
    localparam logic [63:0] STAT = KEY + 64'd8;

    localparam logic [1:0] OP_PUSH = 2'd0;
    localparam logic [1:0] OP_RD   = 2'd1;
    localparam logic [1:0] OP_WR   = 2'd2;

    typedef struct packed {
        logic [1:0]  op;
        logic [63:0] addr;
        logic [63:0] data;
        logic [63:0] exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       key_valid = 1'b0;
    logic [7:0] key_data = '0;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready = 1'b0;

    int checks = 0;
    int failures = 0;
    logic [63:0] exp_q[$];
    vec_t        vecs[$];
    logic        rd_seen = 1'b0;

    bus_responder_if tif();

    bus_responder #(.KEY_ADDR(KEY), .ART_ADDR(ART), .STAT_ADDR(STAT), .FIFO_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .bus(tif),
        .key_valid(key_valid), .key_data(key_data),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(posedge clk) rd_seen <= tif.bus_read_enable;

    always @(negedge clk) begin
        if (rd_seen) begin
            if (exp_q.size() == 0) begin
                check("read_without_expectation", tif.bus_read_data, 64'hDEAD);
            end else begin
                check("bus_read_data", tif.bus_read_data, exp_q.pop_front());
            end
        end
    end

    task automatic push(input logic [7:0] b);
        key_valid = 1'b1;
        key_data  = b;
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    task automatic rd(input logic [63:0] a, input logic [63:0] e);
        exp_q.push_back(e);
        tif.bus_address     = a;
        tif.bus_read_enable = 1'b1;
        @(negedge clk);
        tif.bus_read_enable = 1'b0;
    endtask

    task automatic wr(input logic [63:0] a, input logic [63:0] d);
        tif.bus_address      = a;
        tif.bus_write_data   = d;
        tif.bus_write_enable = 1'b1;
        @(negedge clk);
        tif.bus_write_enable = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic ack();
        tif.interrupt_ack = 1'b1;
        @(negedge clk);
        tif.interrupt_ack = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tif.bus_address      = '0;
        tif.bus_read_enable  = 1'b0;
        tif.bus_write_enable = 1'b0;
        tif.bus_write_data   = '0;
        tif.interrupt_ack    = 1'b0;

        vecs.push_back('{OP_PUSH, 64'h0, 64'h41, 64'h0});
        vecs.push_back('{OP_PUSH, 64'h0, 64'h42, 64'h0});
        vecs.push_back('{OP_RD,   STAT,  64'h0, 64'h0A1});
        vecs.push_back('{OP_RD,   KEY,   64'h0, 64'h141});
        vecs.push_back('{OP_RD,   KEY,   64'h0, 64'h142});
        vecs.push_back('{OP_RD,   KEY,   64'h0, 64'h0});
        vecs.push_back('{OP_RD,   STAT,  64'h0, 64'h020});
        vecs.push_back('{OP_RD,   ART,   64'h0, 64'h0});
        vecs.push_back('{OP_WR,   STAT,  64'h0, 64'h0});
        for (int i = 0; i < 5; i++) vecs.push_back('{OP_PUSH, 64'h0, 64'(8'h10 + i), 64'h0});
        vecs.push_back('{OP_RD,   STAT,  64'h0, 64'h10B});
        vecs.push_back('{OP_RD,   STAT,  64'h0, 64'h103});
        for (int i = 0; i < 4; i++) vecs.push_back('{OP_RD, KEY, 64'h0, 64'h110 + 64'(i)});
        vecs.push_back('{OP_RD,   KEY,   64'h0, 64'h0});

        idle(2);
        check("reset_rdata", tif.bus_read_data, 64'h0);
        check("reset_vector", 64'(tif.interrupt_vector), 64'h0);
        check("reset_tx_valid", 64'(tx_valid), 64'h0);
        reset = 1'b1;
        idle(1);

        foreach (vecs[i]) begin
            case (vecs[i].op)
                OP_PUSH: push(vecs[i].data[7:0]);
                OP_RD:   rd(vecs[i].addr, vecs[i].exp);
                default: wr(vecs[i].addr, vecs[i].data);
            endcase
        end
        idle(1);
        check("vector_disabled", 64'(tif.interrupt_vector), 64'h0);

        wr(STAT, 64'h1);
        push(8'h55);
        check("irq_latency_e", 64'(tif.interrupt_vector), 64'h0);
        idle(1);
        check("irq_latency_e1", 64'(tif.interrupt_vector), 64'h1);
        for (int i = 0; i < 10; i++) begin
            idle(1);
            check("irq_held", 64'(tif.interrupt_vector), 64'h1);
        end
        ack();
        check("irq_acked", 64'(tif.interrupt_vector), 64'h0);
        push(8'h66);
        check("irq_service_push", 64'(tif.interrupt_vector), 64'h0);
        rd(KEY, 64'h155);
        check("irq_after_read", 64'(tif.interrupt_vector), 64'h0);
        idle(1);
        check("irq_reraise", 64'(tif.interrupt_vector), 64'h1);
        ack();
        rd(KEY, 64'h166);
        idle(2);
        check("irq_drained", 64'(tif.interrupt_vector), 64'h0);

        wr(ART, 64'h48);
        check("tx_valid_load", 64'(tx_valid), 64'h1);
        check("tx_data_load", 64'(tx_data), 64'h48);
        wr(ART, 64'h49);
        check("tx_data_held", 64'(tx_data), 64'h48);
        rd(STAT, 64'h034);
        tx_ready = 1'b1;
        @(negedge clk);
        tx_ready = 1'b0;
        check("tx_valid_cleared", 64'(tx_valid), 64'h0);
        rd(STAT, 64'h020);

        wr(STAT, 64'h0);
        push(8'h77);
        idle(3);
        check("irq_en_off", 64'(tif.interrupt_vector), 64'h0);
        wr(STAT, 64'h1);
        check("irq_en_on_e", 64'(tif.interrupt_vector), 64'h0);
        idle(1);
        check("irq_en_on_e1", 64'(tif.interrupt_vector), 64'h1);

        push(8'h78);
        push(8'h79);
        wr(ART, 64'h5A);
        rd(STAT, 64'h0E5);
        check("pre_reset_tx_valid", 64'(tx_valid), 64'h1);
        #2 reset = 1'b0;
        #1;
        check("async_rdata", tif.bus_read_data, 64'h0);
        check("async_vector", 64'(tif.interrupt_vector), 64'h0);
        check("async_tx_valid", 64'(tx_valid), 64'h0);
        check("async_tx_data", 64'(tx_data), 64'h0);
        @(negedge clk);
        reset = 1'b1;
        rd(STAT, 64'h020);
        rd(KEY, 64'h0);
        idle(2);
        check("scoreboard_drained", 64'(exp_q.size()), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
